// File: rtl/rd_wb_queue_16x16.sv
// rd_wb_queue_16x16: write-back queue for the 16 x DW register file.
// Destination writes arrive over a valid/ready handshake, wait in an
// in-order circular queue, and commit one per cycle into the register
// array unless wb_stall holds the head. pend_o flags registers that still
// have a queued write, so decode can detect read-after-write hazards.
// Optional feature macro: RD_R0_ZERO_EN (reg 0 hardwired to zero; writes
// to reg 0 complete the handshake but are dropped).
module rd_wb_queue_16x16 #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [3:0]                rd_sel,
  input  logic [DW-1:0]             rd_data,
  input  logic                      wb_stall,
  output logic [16*DW-1:0]          regs_o,
  output logic [15:0]               pend_o,
  output logic [$clog2(DEPTH):0]    cnt_o,
  output logic                      commit_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Queue storage holds only data and destination; validity comes from
  // head/count, so the storage itself never needs a reset.
  logic [3:0]    sel_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [DW-1:0] regs   [16];

  logic push_hs;
  logic enq;
  logic commit;

  // Ready comes from the registered count only; a commit in the same cycle
  // does not open a slot for a request arriving while full.
  assign wr_ready = (count != FULL_CNT);
  assign push_hs  = wr_valid && wr_ready;
`ifdef RD_R0_ZERO_EN
  assign enq      = push_hs && (rd_sel != 4'd0);
`else
  assign enq      = push_hs;
`endif
  assign commit   = (count != '0) && !wb_stall;
  assign cnt_o    = count;

  // Queue control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)    tail <= tail + PW'(1);
      if (commit) head <= head + PW'(1);
      case ({enq, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: written at the tail on an accepted, enqueued push.
  always_ff @(posedge clk) begin
    if (enq) begin
      sel_q[tail]  <= rd_sel;
      data_q[tail] <= rd_data;
    end
  end

  // Register array and commit pulse; array update and pulse land together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      commit_o <= 1'b0;
    end else begin
      commit_o <= commit;
      if (commit) begin
`ifdef RD_R0_ZERO_EN
        if (sel_q[head] != 4'd0) regs[sel_q[head]] <= data_q[head];
`else
        regs[sel_q[head]] <= data_q[head];
`endif
      end
    end
  end

  // Flatten the array for the read muxes; only committed values are shown.
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < 16; i++) regs_o[i*DW +: DW] = regs[i];
  end

  // Pending mask: an entry is live when its distance from head is < count.
  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - head} < count) pend_o[sel_q[i]] = 1'b1;
    end
`ifdef RD_R0_ZERO_EN
    pend_o[0] = 1'b0;
`endif
  end

endmodule
